wb_stage: RTL

//  Write-back stage feeding the 8x16 GPR file's single write port. Buffers results from the
//  ALU and load (MEM) paths in per-source FIFOs, arbitrates between them, and drives one

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/wb_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
//   DATA_W / ADDR_W / NUM_REGS : GPR file geometry (8 x 16-bit)
//   wb_entry_t                 : one queued result (destination + data)
//   wb_src_e                   : which source FIFO the arbiter selected
//   dest_onehot()              : register index -> one-hot register mask
package wb_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [ADDR_W-1:0] d);
        return NUM_REGS'(1) << d;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of wb_entry_t used once per result source.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push         : write wr_entry this edge (ignored when full)
//   pop          : drop the head entry this edge (ignored when empty)
//   wr_entry     : entry to write
//   full, empty  : occupancy flags, registered state only
//   head         : oldest entry (valid when !empty)
//   entry_valid  : per-slot occupancy vector
//   entry_dest   : per-slot destination field (meaningful where entry_valid is set)
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  wb_entry_t                      wr_entry,
    output logic                           full,
    output logic                           empty,
    output wb_entry_t                      head,
    output logic [DEPTH-1:0]               entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   entry_dest
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t          slots [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    // A full FIFO refuses a push even while it pops in the same cycle:
    // the full flag alone gates acceptance, there is no pass-through.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= wr_entry;
    end

    // Slot i is occupied when its distance from rd_ptr is below count.
    always_comb begin
        logic [PTR_W-1:0] off;
        off         = '0;
        entry_valid = '0;
        entry_dest  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PTR_W'(i) - rd_ptr;
            entry_valid[i] = (CNT_W'(off) < count);
            entry_dest[i]  = slots[i].dest;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: buffers ALU and load results, arbitrates one result per
// cycle onto the registered GPR write port, and reports pending destinations.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   alu_valid/alu_ready          : ALU result handshake, alu_dest/alu_data payload
//   mem_valid/mem_ready          : load result handshake, mem_dest/mem_data payload
//   reg_write/_dest/_data        : registered GPR write port
//   busy_mask                    : bit i set while a write to reg i is queued or on the port
//
// Handshake: a result transfers at a rising edge where valid && ready. ready is
// a function of the FIFO full flag only; while valid is high and ready is low
// the producer holds dest/data stable.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_dest,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_dest,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 reg_write,
    output logic [ADDR_W-1:0]    reg_write_dest,
    output logic [DATA_W-1:0]    reg_write_data,
    output logic [NUM_REGS-1:0]  busy_mask
);

    localparam int SCNT_W = $clog2(STARVE_LIM + 1);

    logic                          alu_full, alu_empty, mem_full, mem_empty;
    logic                          alu_push, mem_push, alu_pop, mem_pop;
    wb_entry_t                     alu_head, mem_head, alu_in, mem_in, pop_entry;
    logic [DEPTH-1:0]              alu_ev, mem_ev;
    logic [DEPTH-1:0][ADDR_W-1:0]  alu_ed, mem_ed;
    wb_src_e                       sel;
    logic [SCNT_W-1:0]             starve_cnt;
    logic [SCNT_W-1:0]             starve_nxt;

    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;
    assign alu_in    = '{dest: alu_dest, data: alu_data};
    assign mem_in    = '{dest: mem_dest, data: mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (alu_push),
        .pop         (alu_pop),
        .wr_entry    (alu_in),
        .full        (alu_full),
        .empty       (alu_empty),
        .head        (alu_head),
        .entry_valid (alu_ev),
        .entry_dest  (alu_ed)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (mem_push),
        .pop         (mem_pop),
        .wr_entry    (mem_in),
        .full        (mem_full),
        .empty       (mem_empty),
        .head        (mem_head),
        .entry_valid (mem_ev),
        .entry_dest  (mem_ed)
    );

    // Loads normally win; ALU wins when it is the only source or has lost
    // STARVE_LIM times in a row.
    always_comb begin
        sel     = SRC_MEM;
        alu_pop = 1'b0;
        mem_pop = 1'b0;
        if (!alu_empty && (mem_empty || starve_cnt == SCNT_W'(STARVE_LIM))) begin
            sel     = SRC_ALU;
            alu_pop = 1'b1;
        end else if (!mem_empty) begin
            mem_pop = 1'b1;
        end
        pop_entry = (sel == SRC_ALU) ? alu_head : mem_head;
    end

    // A non-empty ALU FIFO that does not pop has necessarily lost to MEM.
    always_comb begin
        starve_nxt = starve_cnt;
        if (alu_empty || alu_pop) begin
            starve_nxt = '0;
        end else if (starve_cnt != SCNT_W'(STARVE_LIM)) begin
            starve_nxt = starve_cnt + SCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt     <= '0;
            reg_write      <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            reg_write  <= alu_pop || mem_pop;
            if (alu_pop || mem_pop) begin
                reg_write_dest <= pop_entry.dest;
                reg_write_data <= pop_entry.data;
            end
        end
    end

    // Built only from registered FIFO/output state, never from input ports.
    always_comb begin
        busy_mask = reg_write ? dest_onehot(reg_write_dest) : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_ev[i]) busy_mask = busy_mask | dest_onehot(alu_ed[i]);
            if (mem_ev[i]) busy_mask = busy_mask | dest_onehot(mem_ed[i]);
        end
    end

endmodule
